// File: rtl/mxint8_block_assembler_if.sv
// Stream bundle for mxint8_block_assembler: element input stream and assembled-block output stream.
// o_sat exists only when MXINT8_ASSEMBLER_SAT_EN is defined.
interface mxint8_block_assembler_if #(
  parameter int BLOCK_SIZE  = 32,
  parameter int ELEM_WIDTH  = 8,
  parameter int SCALE_WIDTH = 8
);
  localparam int LEN_W = $clog2(BLOCK_SIZE + 1);

  logic                   i_elem_valid;
  logic                   o_elem_ready;
  logic [ELEM_WIDTH-1:0]  i_elem;
  logic                   i_elem_last;
  logic [SCALE_WIDTH-1:0] i_scale;

  logic                   o_blk_valid;
  logic                   i_blk_ready;
  logic [ELEM_WIDTH-1:0]  o_mxint8_elements [0:BLOCK_SIZE-1];
  logic [SCALE_WIDTH-1:0] o_scale;
  logic [LEN_W-1:0]       o_len;
  logic                   o_padded;
`ifdef MXINT8_ASSEMBLER_SAT_EN
  logic                   o_sat;
`endif

  // Assembler side
  modport slave (
    input  i_elem_valid, i_elem, i_elem_last, i_scale, i_blk_ready,
    output o_elem_ready, o_blk_valid, o_mxint8_elements, o_scale, o_len, o_padded
`ifdef MXINT8_ASSEMBLER_SAT_EN
    , output o_sat
`endif
  );

  // Producer/consumer side
  modport master (
    output i_elem_valid, i_elem, i_elem_last, i_scale, i_blk_ready,
    input  o_elem_ready, o_blk_valid, o_mxint8_elements, o_scale, o_len, o_padded
`ifdef MXINT8_ASSEMBLER_SAT_EN
    , input o_sat
`endif
  );
endinterface

// File: rtl/mxint8_block_assembler.sv
// Serial-to-block front end: collects MXINT8 elements plus shared E8M0 scale into one parallel block.
// Define MXINT8_ASSEMBLER_SAT_EN to rewrite element 0x80 as 0x81 and report it on o_sat.
module mxint8_block_assembler #(
  parameter int BLOCK_SIZE  = 32,
  parameter int ELEM_WIDTH  = 8,
  parameter int SCALE_WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  mxint8_block_assembler_if.slave bus
);
  localparam int CNT_W = $clog2(BLOCK_SIZE);
  localparam int LEN_W = $clog2(BLOCK_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BLOCK_SIZE);

  typedef enum logic {S_COLLECT, S_PENDING} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;

  logic [ELEM_WIDTH-1:0]  r_cbuf [0:BLOCK_SIZE-1];
  logic [SCALE_WIDTH-1:0] r_cscale;
  logic [CNT_W-1:0]       r_cnt;
  logic [LEN_W-1:0]       r_len;

  logic [ELEM_WIDTH-1:0]  r_elems [0:BLOCK_SIZE-1];
  logic [SCALE_WIDTH-1:0] r_scale;
  logic [LEN_W-1:0]       r_out_len;
  logic                   r_padded;
  logic                   r_blk_valid;

  logic                   w_elem_ready;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_complete;
  logic                   w_slot_free;
  logic                   w_load;
  logic [ELEM_WIDTH-1:0]  w_elem_in;
  logic [ELEM_WIDTH-1:0]  w_src_elems [0:BLOCK_SIZE-1];
  logic [SCALE_WIDTH-1:0] w_src_scale;
  logic [LEN_W-1:0]       w_src_len;

  // Handshake and block-boundary decode
  assign w_elem_ready = rst_n & (r_state == S_COLLECT);
  assign w_accept     = bus.i_elem_valid & w_elem_ready;
  assign w_first      = (r_cnt == '0);
  assign w_complete   = w_accept & ((r_cnt == LAST_IDX) | bus.i_elem_last);
  assign w_slot_free  = ~r_blk_valid | bus.i_blk_ready;

`ifdef MXINT8_ASSEMBLER_SAT_EN
  logic w_rewrite;
  logic w_csat_nxt;
  logic r_csat;
  logic r_sat;

  // 0x80 has no symmetric positive partner; clamp it to 0x81
  assign w_rewrite  = (bus.i_elem == {1'b1, {(ELEM_WIDTH-1){1'b0}}});
  assign w_elem_in  = w_rewrite ? {1'b1, {(ELEM_WIDTH-2){1'b0}}, 1'b1} : bus.i_elem;
  assign w_csat_nxt = w_accept ? ((r_csat & ~w_first) | w_rewrite) : r_csat;
`else
  assign w_elem_in  = bus.i_elem;
`endif

  // A pending block has no accept in flight, so one source path serves both load cases
  assign w_src_len   = (r_state == S_PENDING) ? r_len : (LEN_W'(r_cnt) + LEN_W'(1));
  assign w_src_scale = (w_accept & w_first) ? bus.i_scale : r_cscale;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      w_src_elems[i] = r_cbuf[i];
      if (w_accept && (r_cnt == CNT_W'(i))) w_src_elems[i] = w_elem_in;
      if (LEN_W'(i) >= w_src_len)          w_src_elems[i] = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_complete) begin
          if (w_slot_free) w_load = 1'b1;
          else             w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the collect buffer is not reset; entries at or beyond len are masked on load.
  always_ff @(posedge clk) begin
    if (w_accept) r_cbuf[r_cnt] <= w_elem_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_cscale <= '0;
      r_len    <= '0;
`ifdef MXINT8_ASSEMBLER_SAT_EN
      r_csat   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt <= w_complete ? '0 : (r_cnt + 1'b1);
      if (w_first)    r_cscale <= bus.i_scale;
      if (w_complete) r_len    <= w_src_len;
`ifdef MXINT8_ASSEMBLER_SAT_EN
      r_csat <= w_csat_nxt;
`endif
    end
  end

  // Output register set; a load and a drain on the same edge keep valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elems     <= '{default: '0};
      r_scale     <= '0;
      r_out_len   <= '0;
      r_padded    <= 1'b0;
      r_blk_valid <= 1'b0;
`ifdef MXINT8_ASSEMBLER_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_elems   <= w_src_elems;
        r_scale   <= w_src_scale;
        r_out_len <= w_src_len;
        r_padded  <= (w_src_len != FULL_LEN);
`ifdef MXINT8_ASSEMBLER_SAT_EN
        r_sat     <= w_csat_nxt;
`endif
      end
      if (w_load)                r_blk_valid <= 1'b1;
      else if (bus.i_blk_ready)  r_blk_valid <= 1'b0;
    end
  end

  assign bus.o_elem_ready      = w_elem_ready;
  assign bus.o_blk_valid       = r_blk_valid;
  assign bus.o_mxint8_elements = r_elems;
  assign bus.o_scale           = r_scale;
  assign bus.o_len             = r_out_len;
  assign bus.o_padded          = r_padded;
`ifdef MXINT8_ASSEMBLER_SAT_EN
  assign bus.o_sat             = r_sat;
`endif
endmodule

// File: tb/tb_mxint8_block_assembler.sv
// Self-checking bench for mxint8_block_assembler: directed scenarios plus random blocks,
// scored against a queue-of-blocks reference model built from accepted elements.
module tb_mxint8_block_assembler;
  localparam int BS = 32;
  localparam int EW = 8;
  localparam int SW = 8;
  localparam int VW = BS * EW;

  typedef struct {
    logic [VW-1:0] elems;
    logic [SW-1:0] scale;
    int            len;
    bit            sat;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mxint8_block_assembler_if #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) bus ();

  mxint8_block_assembler #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int       n_vec = 0;
  int       n_err = 0;
  int       n_blk = 0;
  int       stalls = 0;
  bit       rnd_ready = 0;
  time      last_acc_t;
  blk_t     exp_q[$];
  logic [EW-1:0] cur[$];
  logic [SW-1:0] cur_scale;
  bit       cur_sat;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] flat_out();
    logic [VW-1:0] v;
    for (int k = 0; k < BS; k++) v[k*EW +: EW] = bus.o_mxint8_elements[k];
    return v;
  endfunction

  // Reference model: a block is the list of accepted elements, zero-padded to BS
  task automatic model_accept(input logic [EW-1:0] e, input logic [SW-1:0] s, input bit last);
    logic [EW-1:0] stored;
    blk_t b;
    stored = e;
    if (cur.size() == 0) begin
      cur_scale = s;
      cur_sat   = 0;
    end
`ifdef MXINT8_ASSEMBLER_SAT_EN
    if (e == 8'h80) begin
      stored  = 8'h81;
      cur_sat = 1;
    end
`endif
    cur.push_back(stored);
    if (last || cur.size() == BS) begin
      b.elems = '0;
      for (int k = 0; k < cur.size(); k++) b.elems[k*EW +: EW] = cur[k];
      b.scale = cur_scale;
      b.len   = cur.size();
      b.sat   = cur_sat;
      exp_q.push_back(b);
      cur.delete();
    end
  endtask

  task automatic compare_block(input string tag, input blk_t b);
    check({tag, ".elems"},  flat_out(),     b.elems);
    check({tag, ".scale"},  bus.o_scale,    b.scale);
    check({tag, ".len"},    bus.o_len,      b.len);
    check({tag, ".padded"}, bus.o_padded,   (b.len != BS));
`ifdef MXINT8_ASSEMBLER_SAT_EN
    check({tag, ".sat"},    bus.o_sat,      b.sat);
`endif
  endtask

  // Every block handed downstream is scored against the oldest model block
  always @(negedge clk) begin : mon
    blk_t b;
    if (rst_n && bus.o_blk_valid && bus.i_blk_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", 1, 0);
      end else begin
        b = exp_q.pop_front();
        compare_block("drain", b);
        n_blk++;
      end
    end
  end

  task automatic send_elem(input logic [EW-1:0] e, input logic [SW-1:0] s, input bit last);
    int waited = 0;
    bit ok = 1;
    bus.i_elem_valid = 1'b1;
    bus.i_elem       = e;
    bus.i_scale      = s;
    bus.i_elem_last  = last;
    forever begin
      @(negedge clk);
      if (bus.o_elem_ready) break;
      waited++;
      stalls++;
      if (waited > 300) begin
        check("elem_ready_timeout", 0, 1);
        ok = 0;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) bus.i_blk_ready = 1'($urandom_range(0, 1));
    end
    if (ok) begin
      @(posedge clk);
      last_acc_t = $time;
      #1;
      model_accept(e, s, last);
      if (rnd_ready) bus.i_blk_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle();
    bus.i_elem_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bus.i_elem_valid = 1'b0;
    bus.i_blk_ready  = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.o_blk_valid) break;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] rnd_elem();
    return ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [SW-1:0] scl [4];
    logic [EW-1:0] e;
    int            base, len;
    time           t0;

    bus.i_elem_valid = 1'b0;
    bus.i_elem       = '0;
    bus.i_elem_last  = 1'b0;
    bus.i_scale      = '0;
    bus.i_blk_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid",  bus.o_blk_valid,  0);
    check("rst.ready",  bus.o_elem_ready, 0);
    check("rst.len",    bus.o_len,        0);
    check("rst.scale",  bus.o_scale,      0);
    check("rst.padded", bus.o_padded,     0);
    check("rst.elems",  flat_out(),       0);
`ifdef MXINT8_ASSEMBLER_SAT_EN
    check("rst.sat",    bus.o_sat,        0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.ready", bus.o_elem_ready, 1);
    @(posedge clk);
    #1;

    // 1: full block 0x01..0x20, scale on element 0 only
    bus.i_blk_ready = 1'b1;
    for (int i = 0; i < BS; i++) send_elem(8'(i + 1), (i == 0) ? 8'h7F : 8'($urandom), 1'b0);
    bus.i_elem_valid = 1'b0;
    @(negedge clk);
    check("t1.valid",  bus.o_blk_valid,           1);
    check("t1.e0",     bus.o_mxint8_elements[0],  8'h01);
    check("t1.e31",    bus.o_mxint8_elements[31], 8'h20);
    check("t1.scale",  bus.o_scale,               8'h7F);
    check("t1.len",    bus.o_len,                 32);
    check("t1.padded", bus.o_padded,              0);
    wait_drain();

    // 2: short block of 5, stale buffer contents must not leak into padding
    for (int i = 0; i < 5; i++) send_elem(8'(8'h10 + i), 8'h42, (i == 4));
    bus.i_elem_valid = 1'b0;
    @(negedge clk);
    check("t2.e4",     bus.o_mxint8_elements[4], 8'h14);
    check("t2.e5",     bus.o_mxint8_elements[5], 8'h00);
    check("t2.len",    bus.o_len,                5);
    check("t2.padded", bus.o_padded,             1);
    wait_drain();

    // 3: backpressure across two full blocks
    bus.i_blk_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < BS; i++) send_elem(rnd_elem(), 8'($urandom), 1'b0);
    bus.i_elem_valid = 1'b0;
    @(negedge clk);
    check("t3.ready_low",  bus.o_elem_ready, 0);
    check("t3.valid_held", bus.o_blk_valid,  1);
    check("t3.hold_A",     flat_out(),       exp_q[0].elems);
    repeat (3) @(negedge clk);
    check("t3.still_A",    flat_out(),       exp_q[0].elems);
    check("t3.still_scl",  bus.o_scale,      exp_q[0].scale);
    @(posedge clk);
    #1;
    bus.i_blk_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_blk_ready = 1'b0;
    @(negedge clk);
    check("t3.B_valid",  bus.o_blk_valid,  1);
    check("t3.B_elems",  flat_out(),       exp_q[0].elems);
    check("t3.B_qlen",   exp_q.size(),     1);
    check("t3.ready_up", bus.o_elem_ready, 1);
    wait_drain();

    // 4: four back-to-back blocks, no stalls allowed
    scl[0] = 8'h00; scl[1] = 8'h01; scl[2] = 8'hFE; scl[3] = 8'h7F;
    base   = n_blk;
    stalls = 0;
    t0     = 0;
    bus.i_blk_ready = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < BS; i++) begin
        send_elem(rnd_elem(), (i == 0) ? scl[b] : 8'($urandom),
                  (i == BS - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        if (b == 0 && i == 0) t0 = last_acc_t;
      end
    check("t4.stalls", stalls, 0);
    check("t4.cycles", (last_acc_t - t0) / 10, 4 * BS - 1);
    wait_drain();
    check("t4.blocks", n_blk - base, 4);

    // Random blocks under random backpressure, including a length-1 block
    rnd_ready = 1;
    send_elem(rnd_elem(), 8'($urandom), 1'b1);
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, BS);
      for (int i = 0; i < len; i++) begin
        send_elem(rnd_elem(), 8'($urandom), (i == len - 1) ? 1'b1 : 1'($urandom_range(0, 31) == 0));
        if (cur.size() == 0) break;
        if ($urandom_range(0, 5) == 0) idle();
      end
    end
    rnd_ready = 0;
    wait_drain();

    // 5: reset mid-block with a block still presented
    bus.i_blk_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_elem(8'($urandom), 8'h11, (i == 2));
    for (int i = 0; i < 10; i++) send_elem(8'($urandom), 8'h22, 1'b0);
    bus.i_elem_valid = 1'b0;
    @(negedge clk);
    check("t5.pre_valid", bus.o_blk_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    cur.delete();
    #1;
    check("t5.valid", bus.o_blk_valid,  0);
    check("t5.ready", bus.o_elem_ready, 0);
    check("t5.elems", flat_out(),       0);
    check("t5.len",   bus.o_len,        0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_blk_ready = 1'b1;
    for (int i = 0; i < BS; i++) send_elem(8'($urandom), (i == 0) ? 8'h33 : 8'($urandom), 1'b0);
    wait_drain();

    // 6: 0x80 at index 3, then a clean block
    for (int i = 0; i < 8; i++) begin
      e = (i == 3) ? 8'h80 : 8'(i + 2);
      send_elem(e, 8'h05, (i == 7));
    end
    bus.i_elem_valid = 1'b0;
    @(negedge clk);
`ifdef MXINT8_ASSEMBLER_SAT_EN
    check("t6.e3",  bus.o_mxint8_elements[3], 8'h81);
    check("t6.sat", bus.o_sat,                1);
`else
    check("t6.e3",  bus.o_mxint8_elements[3], 8'h80);
`endif
    wait_drain();
    for (int i = 0; i < 4; i++) send_elem(8'(i + 9), 8'h06, (i == 3));
    wait_drain();

    check("end.queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
